// File: rtl/mux_reg_nto1_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
//   Shared constants and helpers for the registered N:1 selector.
//   DEFAULT_WIDTH : default data width of each input and of the output
//   MAX_NUM_IN    : largest supported number of selectable inputs
//   MAX_WIDTH     : largest supported data width (bounds the slice helper)
//   get_slice()   : extracts slice k of a given width from a packed bus
// -----------------------------------------------------------------------------
package mux_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int MAX_NUM_IN    = 16;
  localparam int MAX_WIDTH     = 256;
  localparam int MAX_BUS_W     = MAX_NUM_IN * MAX_WIDTH;

  // Returns bits [k*width +: width] of bus, zero-extended to MAX_WIDTH.
  // Callers zero-extend their own bus to MAX_BUS_W and keep the low bits.
  function automatic logic [MAX_WIDTH-1:0] get_slice(
    input logic [MAX_BUS_W-1:0] bus,
    input int unsigned          k,
    input int unsigned          width
  );
    logic [MAX_WIDTH-1:0] mask;
    mask = ~({MAX_WIDTH{1'b1}} << width);
    return MAX_WIDTH'(bus >> (k * width)) & mask;
  endfunction

endpackage

// File: rtl/mux_reg_nto1_comb.sv
// -----------------------------------------------------------------------------
// mux_nto1_comb
//   Purely combinational N:1 selector. An out-of-range select yields all-zero
//   data and raises sel_oor so the storage logic can flag the error.
//   Ports:
//     in_flat  [NUM_IN*WIDTH] packed inputs, input k at [k*WIDTH +: WIDTH]
//     sel      [SEL_W]        input select
//     data     [WIDTH]        selected input, or zero when sel >= NUM_IN
//     sel_oor  [1]            sel >= NUM_IN
// -----------------------------------------------------------------------------
module mux_nto1_comb
  import mux_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_flat,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        data,
  output logic                    sel_oor
);

  if (NUM_IN < 2 || NUM_IN > MAX_NUM_IN) begin : g_bad_num_in
    $error("mux_nto1_comb: NUM_IN=%0d outside 2..%0d", NUM_IN, MAX_NUM_IN);
  end
  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("mux_nto1_comb: WIDTH=%0d outside 1..%0d", WIDTH, MAX_WIDTH);
  end

  logic [MAX_BUS_W-1:0] bus_ext;
  logic [MAX_WIDTH-1:0] slice_ext [NUM_IN];
  logic                 unused_hi;

  assign bus_ext = MAX_BUS_W'(in_flat);

  for (genvar k = 0; k < NUM_IN; k++) begin : g_slice
    assign slice_ext[k] = get_slice(bus_ext, k, WIDTH);
  end

  // Upper bits of each extended slice are always zero; fold them away.
  always_comb begin
    unused_hi = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      unused_hi = unused_hi ^ (^slice_ext[k]);
    end
  end

  assign sel_oor = 32'(sel) >= 32'(NUM_IN);

  // Default of zero covers every select value that matches no input.
  always_comb begin
    data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        data = slice_ext[k][WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/mux_reg_nto1.sv
// -----------------------------------------------------------------------------
// mux_reg_nto1
//   Registered N:1 selector with a 2-entry skid buffer on a valid/ready stream.
//   The main register drives the output; the skid register absorbs one word
//   when the output stalls, so in_ready depends only on registered state.
//   Ports:
//     clk        clock, rising edge
//     rst_n      asynchronous active-low reset
//     in_flat    packed inputs, input k at [k*WIDTH +: WIDTH]
//     sel        input select, sampled on accept
//     in_valid   upstream word present
//     in_ready   stage can accept (skid empty)
//     out_data   registered selected data
//     out_valid  out_data holds a word
//     out_ready  downstream accepts out_data
//     flush      discard all held words and any same-cycle accept
//     sel_err    sticky: an out-of-range select was accepted
//     err_clr    clear sel_err (a same-cycle set wins)
// -----------------------------------------------------------------------------
module mux_reg_nto1
  import mux_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_flat,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    flush,
  output logic                    sel_err,
  input  logic                    err_clr
);

  if (NUM_IN < 2 || NUM_IN > MAX_NUM_IN) begin : g_bad_num_in
    $error("mux_reg_nto1: NUM_IN=%0d outside 2..%0d", NUM_IN, MAX_NUM_IN);
  end
  if (SEL_W < $clog2(NUM_IN)) begin : g_bad_sel_w
    $error("mux_reg_nto1: SEL_W=%0d too narrow for NUM_IN=%0d", SEL_W, NUM_IN);
  end

  logic [WIDTH-1:0] sel_data;
  logic             sel_oor;

  logic [WIDTH-1:0] main_data;
  logic             main_valid;
  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;

  logic accept;
  logic drain;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  mux_nto1_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_sel (
    .in_flat (in_flat),
    .sel     (sel),
    .data    (sel_data),
    .sel_oor (sel_oor)
  );

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;

  assign accept = in_valid && in_ready;
  assign drain  = main_valid && out_ready;

  // With skid full, in_ready is low, so an accept and a skid refill can
  // never coincide; the skid word simply moves up on drain.
  assign load_main_in   = !flush && accept && (!main_valid || drain);
  assign load_main_skid = !flush && skid_valid && drain;
  assign load_skid      = !flush && accept && main_valid && !drain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (load_main_in || load_main_skid) begin
        main_valid <= 1'b1;
      end else if (drain) begin
        main_valid <= 1'b0;
      end
      if (load_skid) begin
        skid_valid <= 1'b1;
      end else if (load_main_skid) begin
        skid_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data <= '0;
    end else if (load_main_skid) begin
      main_data <= skid_data;
    end else if (load_main_in) begin
      main_data <= sel_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_data <= '0;
    end else if (load_skid) begin
      skid_data <= sel_data;
    end
  end

  // A flushed accept is discarded entirely, including its error report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else if (accept && sel_oor && !flush) begin
      sel_err <= 1'b1;
    end else if (err_clr) begin
      sel_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_reg_nto1.sv
module tb_mux_reg_nto1;

  logic clk;
  logic rst_n;

  // 4-input instance
  logic [127:0] in_flat4;
  logic [1:0]   sel4;
  logic         in_valid4, in_ready4, out_valid4, out_ready4, flush4, sel_err4, err_clr4;
  logic [31:0]  out_data4;

  // 5-input instance with a 3-bit select
  logic [159:0] in_flat5;
  logic [2:0]   sel5;
  logic         in_valid5, in_ready5, out_valid5, out_ready5, flush5, sel_err5, err_clr5;
  logic [31:0]  out_data5;

  int checks;
  int errors;

  mux_reg_nto1 #(.WIDTH(32), .NUM_IN(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_flat(in_flat4), .sel(sel4),
    .in_valid(in_valid4), .in_ready(in_ready4), .out_data(out_data4),
    .out_valid(out_valid4), .out_ready(out_ready4), .flush(flush4),
    .sel_err(sel_err4), .err_clr(err_clr4)
  );

  mux_reg_nto1 #(.WIDTH(32), .NUM_IN(5), .SEL_W(3)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .in_flat(in_flat5), .sel(sel5),
    .in_valid(in_valid5), .in_ready(in_ready5), .out_data(out_data5),
    .out_valid(out_valid5), .out_ready(out_ready5), .flush(flush5),
    .sel_err(sel_err5), .err_clr(err_clr5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid4); end
    checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready4); end
    checks++; if (sel_err4 !== 1'b0) begin errors++; $display("FAIL reset_sel_err got %0b want 0", sel_err4); end
    checks++; if (out_data4 !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data4); end
    checks++; if (sel_err5 !== 1'b0) begin errors++; $display("FAIL reset_sel_err5 got %0b want 0", sel_err5); end
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_select;
    logic [31:0] exp_tab [4];
    in_flat4   = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    exp_tab[0] = 32'h11111111; exp_tab[1] = 32'h22222222;
    exp_tab[2] = 32'h33333333; exp_tab[3] = 32'h44444444;
    out_ready4 = 1'b1;
    in_valid4  = 1'b1;
    sel4       = 2'd2;
    tick();
    checks++; if (out_valid4 !== 1'b1) begin errors++; $display("FAIL sel2_valid got %0b want 1", out_valid4); end
    checks++; if (out_data4 !== 32'h33333333) begin errors++; $display("FAIL sel2_data got %h want 33333333", out_data4); end
    for (int s = 0; s < 4; s++) begin
      sel4 = 2'(s);
      tick();
      checks++; if (out_data4 !== exp_tab[s]) begin errors++; $display("FAIL sel_sweep_%0d got %h want %h", s, out_data4, exp_tab[s]); end
    end
    in_valid4 = 1'b0;
    tick();
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL sel_idle_valid got %0b want 0", out_valid4); end
  endtask

  task automatic test_back_to_back;
    sel4       = 2'd0;
    out_ready4 = 1'b0;
    in_valid4  = 1'b1;
    in_flat4[31:0] = 32'hAAAA0001;
    tick();
    checks++; if (out_data4 !== 32'hAAAA0001) begin errors++; $display("FAIL b2b_first got %h want aaaa0001", out_data4); end
    checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL b2b_ready1 got %0b want 1", in_ready4); end
    in_flat4[31:0] = 32'hBBBB0002;
    tick();
    checks++; if (in_ready4 !== 1'b0) begin errors++; $display("FAIL b2b_ready_full got %0b want 0", in_ready4); end
    checks++; if (out_data4 !== 32'hAAAA0001) begin errors++; $display("FAIL b2b_hold got %h want aaaa0001", out_data4); end
    in_flat4[31:0] = 32'hCCCC0003;
    tick();
    checks++; if (out_data4 !== 32'hAAAA0001) begin errors++; $display("FAIL b2b_stall got %h want aaaa0001", out_data4); end
    checks++; if (out_valid4 !== 1'b1) begin errors++; $display("FAIL b2b_stall_valid got %0b want 1", out_valid4); end
    out_ready4 = 1'b1;
    tick();
    checks++; if (out_data4 !== 32'hBBBB0002) begin errors++; $display("FAIL b2b_second got %h want bbbb0002", out_data4); end
    checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL b2b_ready_after got %0b want 1", in_ready4); end
    in_valid4 = 1'b0;
    tick();
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL b2b_empty got %0b want 0", out_valid4); end
  endtask

  task automatic test_stream;
    sel4       = 2'd0;
    out_ready4 = 1'b1;
    in_valid4  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_flat4[31:0] = 32'(i + 1);
      tick();
      checks++; if (out_data4 !== 32'(i + 1) || out_valid4 !== 1'b1) begin
        errors++; $display("FAIL stream_%0d got %h/%0b want %h/1", i, out_data4, out_valid4, 32'(i + 1));
      end
      checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL stream_ready_%0d got %0b want 1", i, in_ready4); end
    end
    in_valid4 = 1'b0;
    tick();
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL stream_end got %0b want 0", out_valid4); end
  endtask

  task automatic test_sel_err;
    in_flat5   = {32'h55555555, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    out_ready5 = 1'b1;
    in_valid5  = 1'b1;
    sel5       = 3'd4;
    tick();
    checks++; if (out_data5 !== 32'h55555555) begin errors++; $display("FAIL sel_last_data got %h want 55555555", out_data5); end
    checks++; if (sel_err5 !== 1'b0) begin errors++; $display("FAIL sel_last_err got %0b want 0", sel_err5); end
    sel5 = 3'd6;
    tick();
    checks++; if (out_data5 !== 32'h0 || out_valid5 !== 1'b1) begin errors++; $display("FAIL sel6_data got %h/%0b want 0/1", out_data5, out_valid5); end
    checks++; if (sel_err5 !== 1'b1) begin errors++; $display("FAIL sel6_err got %0b want 1", sel_err5); end
    sel5 = 3'd1;
    tick();
    checks++; if (out_data5 !== 32'h22222222) begin errors++; $display("FAIL sel1_data got %h want 22222222", out_data5); end
    checks++; if (sel_err5 !== 1'b1) begin errors++; $display("FAIL err_sticky got %0b want 1", sel_err5); end
    in_valid5 = 1'b0;
    err_clr5  = 1'b1;
    tick();
    checks++; if (sel_err5 !== 1'b0) begin errors++; $display("FAIL err_clear got %0b want 0", sel_err5); end
    sel5 = 3'd5;
    in_valid5 = 1'b1;
    tick();
    checks++; if (sel_err5 !== 1'b1) begin errors++; $display("FAIL err_set_wins got %0b want 1", sel_err5); end
    checks++; if (out_data5 !== 32'h0) begin errors++; $display("FAIL sel5_data got %h want 0", out_data5); end
    err_clr5  = 1'b0;
    in_valid5 = 1'b0;
    tick();
    checks++; if (sel_err5 !== 1'b1) begin errors++; $display("FAIL err_hold got %0b want 1", sel_err5); end
  endtask

  task automatic test_flush;
    sel4       = 2'd0;
    out_ready4 = 1'b0;
    in_valid4  = 1'b1;
    in_flat4[31:0] = 32'hF0000001;
    tick();
    in_flat4[31:0] = 32'hF0000002;
    tick();
    checks++; if (in_ready4 !== 1'b0) begin errors++; $display("FAIL flush_full got %0b want 0", in_ready4); end
    in_flat4[31:0] = 32'hF0000003;
    flush4 = 1'b1;
    tick();
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", out_valid4); end
    checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL flush_ready got %0b want 1", in_ready4); end
    in_flat4[31:0] = 32'hF0000004;
    tick();
    flush4     = 1'b0;
    in_valid4  = 1'b0;
    out_ready4 = 1'b1;
    tick();
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL flush_no_deliver got %0b want 0", out_valid4); end
  endtask

  task automatic test_async_reset;
    sel4       = 2'd0;
    out_ready4 = 1'b0;
    in_valid4  = 1'b1;
    in_flat4[31:0] = 32'hD0000001;
    tick();
    in_flat4[31:0] = 32'hD0000002;
    tick();
    in_valid4 = 1'b0;
    checks++; if (in_ready4 !== 1'b0 || out_valid4 !== 1'b1) begin errors++; $display("FAIL areset_pre got %0b/%0b want 0/1", in_ready4, out_valid4); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL areset_valid got %0b want 0", out_valid4); end
    checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL areset_ready got %0b want 1", in_ready4); end
    checks++; if (out_data4 !== 32'h0) begin errors++; $display("FAIL areset_data got %h want 0", out_data4); end
    #3 rst_n = 1'b1;
    in_valid4 = 1'b1;
    in_flat4[31:0] = 32'hE0000001;
    tick();
    checks++; if (out_data4 !== 32'hE0000001 || out_valid4 !== 1'b1) begin errors++; $display("FAIL areset_first got %h/%0b want e0000001/1", out_data4, out_valid4); end
    checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL areset_first_ready got %0b want 1", in_ready4); end
    in_valid4  = 1'b0;
    out_ready4 = 1'b1;
    tick();
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL areset_drain got %0b want 0", out_valid4); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    in_flat4 = '0; sel4 = '0; in_valid4 = 1'b0; out_ready4 = 1'b0; flush4 = 1'b0; err_clr4 = 1'b0;
    in_flat5 = '0; sel5 = '0; in_valid5 = 1'b0; out_ready5 = 1'b0; flush5 = 1'b0; err_clr5 = 1'b0;
    test_reset();
    test_select();
    test_back_to_back();
    test_stream();
    test_sel_err();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_reg_nto1.md
MUX_REG_NTO1 -- requirements
Module: mux_reg_nto1

Interface
REQ-001 Parameter WIDTH, default 32, data width of each input and of the output, in bits.
REQ-002 Parameter NUM_IN, default 4, number of selectable inputs; legal range 2..16.
REQ-003 Parameter SEL_W, default $clog2(NUM_IN), width of the select field.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port in_flat  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
REQ-007 Port sel  input  SEL_W  input select, sampled with in_valid.
REQ-008 Port in_valid  input  1  upstream presents in_flat/sel.
REQ-009 Port in_ready  output  1  stage can accept this cycle.
REQ-010 Port out_data  output  WIDTH  selected, registered data.
REQ-011 Port out_valid  output  1  out_data is valid.
REQ-012 Port out_ready  input  1  downstream accepts out_data (0 = stall).
REQ-013 Port flush  input  1  synchronous discard of all held entries.
REQ-014 Port sel_err  output  1  sticky flag: an out-of-range sel was accepted.
REQ-015 Port err_clr  input  1  synchronous clear of sel_err.

Function
REQ-016 Accept occurs when in_valid && in_ready; the accepted word is in[sel], or all-zero if sel >= NUM_IN.
REQ-017 Storage is a 2-entry skid buffer: main register (drives out_data/out_valid) and skid register.
REQ-018 Latency is 1 cycle: a word accepted at edge N is visible on out_data after edge N when main is empty or draining.
REQ-019 in_ready = !skid_valid; it is registered-state-only, with no combinational path from out_ready.
REQ-020 Output transfer occurs when out_valid && out_ready; out_data SHALL hold stable while out_valid && !out_ready.
REQ-021 Accept with main empty: word goes to main.
REQ-022 Accept with main full and main draining: word goes to main.
REQ-023 Accept with main full and not draining: word goes to skid.
REQ-024 Drain with skid full: skid moves to main in the same edge, and skid empties.
REQ-025 Simultaneous accept and drain with main full and skid empty: main is replaced by the new word; occupancy is unchanged.
REQ-026 Words leave in acceptance order; no word is duplicated or lost except by flush.
REQ-027 Flush empties main and skid at the next edge, and any accept in the same cycle is discarded; flush takes priority over all other updates.
REQ-028 sel_err sets on an accept with sel >= NUM_IN.
REQ-029 sel_err clears on err_clr; if set and clear occur in the same cycle, set wins.
REQ-030 Data registers update only when loaded (no toggling on idle cycles).

Reset
REQ-031 While rst_n = 0, out_valid = 0, skid empty, in_ready = 1, sel_err = 0, and out_data = 0, asynchronously.
REQ-032 Deassertion of rst_n mid-stream discards all held words; the first accept after reset behaves as accept-into-empty.

Structure
REQ-033 Shared package mux_pkg holds DEFAULT_WIDTH = 32, MAX_NUM_IN = 16, and a function that extracts slice k from a packed bus.
REQ-034 One sub-module mux_nto1_comb (parametrised WIDTH/NUM_IN combinational N:1 selector with zero-on-out-of-range) feeds the storage logic.
REQ-035 Parameter checks SHALL raise an elaboration error for NUM_IN < 2 or NUM_IN > MAX_NUM_IN.

Verification
REQ-036 Scenario: NUM_IN=4, inputs 0x11111111/0x22222222/0x33333333/0x44444444, sel=2, out_ready=1 -> out_data=0x33333333, out_valid=1 one cycle after the accept.
REQ-037 Scenario: out_ready=0, two back-to-back accepts A, B -> in_ready=0 after the second accept; out_ready=1 -> A is delivered, then B, with no loss.
REQ-038 Scenario: continuous in_valid and out_ready=1 for 100 cycles with an incrementing counter on in0 and sel=0 -> output is the same incrementing sequence at full throughput, and in_ready stays 1.
REQ-039 Scenario: NUM_IN=5, SEL_W=3, sel=6 accepted -> out_data=0 and sel_err=1 until err_clr; with err_clr and a new bad sel in the same cycle, sel_err stays 1.
REQ-040 Scenario: both entries full, then flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed-cycle word is not delivered.
REQ-041 Scenario: rst_n driven low between clock edges with both entries full -> out_valid=0 and in_ready=1 immediately, without waiting for an edge.
